// File: rtl/bus_scheduler_if.sv
// Bus scheduler signal bundle: DMA request lines and slave strobe in,
// one-hot grant, busy flag and watchdog error reporting out.
interface bus_scheduler_if;
  logic [7:0] dma;
  logic       ready;
  logic [7:0] grant;
  logic       req;
  logic       timeout_err;
  logic [2:0] err_id;

  // Scheduler side: samples requests and slave strobe, drives grants.
  modport master (
    input  dma,
    input  ready,
    output grant,
    output req,
    output timeout_err,
    output err_id
  );

  // Environment side: DMA masters and slave.
  modport slave (
    output dma,
    output ready,
    input  grant,
    input  req,
    input  timeout_err,
    input  err_id
  );
endinterface

// File: rtl/bus_scheduler.sv
// Round-robin scheduler for eight DMA masters. Each tenure is capped at
// MAX_BURST ready strobes; a watchdog aborts a tenure after TIMEOUT busy
// cycles without ready. All outputs come straight from registers.
module bus_scheduler #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   clr,
  bus_scheduler_if.master        bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [7:0]  BURST_LIM = 8'(MAX_BURST);
  localparam logic [15:0] WDOG_LIM  = 16'(TIMEOUT);

  state_t      state;
  logic [2:0]  ptr;
  logic [2:0]  owner;
  logic [7:0]  burst_cnt;
  logic [15:0] wdog;
  logic [7:0]  grant_q;
  logic        timeout_q;
  logic [2:0]  err_id_q;

  logic [2:0]  sel;
  logic        sel_found;
  logic [2:0]  idx;
  logic        owner_req;
  logic [7:0]  burst_nxt;
  logic [15:0] wdog_nxt;
  logic        wdog_fire;
  logic        release_now;

  // Rotating-priority pick: first requesting master at or after ptr.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!sel_found && bus.dma[idx]) begin
        sel       = idx;
        sel_found = 1'b1;
      end
    end
  end

  // Tenure-end decision while BUSY; ready takes precedence over the
  // watchdog, and burst-limit plus withdrawal collapse into one release.
  always_comb begin
    owner_req   = bus.dma[owner];
    burst_nxt   = burst_cnt + 8'd1;
    wdog_nxt    = wdog + 16'd1;
    wdog_fire   = !bus.ready && owner_req && (wdog_nxt == WDOG_LIM);
    release_now = bus.ready ? ((burst_nxt == BURST_LIM) || !owner_req)
                            : (!owner_req || wdog_fire);
  end

  // Scheduler FSM with registered grant and error outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      wdog      <= '0;
      grant_q   <= '0;
      timeout_q <= 1'b0;
      err_id_q  <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            owner     <= sel;
            grant_q   <= 8'(1) << sel;
            burst_cnt <= '0;
            wdog      <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (release_now) begin
            state     <= IDLE;
            grant_q   <= '0;
            ptr       <= owner + 3'd1;
            burst_cnt <= '0;
            wdog      <= '0;
            if (wdog_fire) begin
              timeout_q <= 1'b1;
              err_id_q  <= owner;
            end
          end else if (bus.ready) begin
            burst_cnt <= burst_nxt;
            wdog      <= '0;
          end else begin
            wdog <= wdog_nxt;
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.req         = |grant_q;
  assign bus.timeout_err = timeout_q;
  assign bus.err_id      = err_id_q;

endmodule

// File: tb/tb_bus_scheduler.sv
// Scoreboard bench for bus_scheduler. Two instances: A (MAX_BURST=1,
// TIMEOUT=8) for rotation and async reset, B (MAX_BURST=4, TIMEOUT=8)
// for burst cap, withdrawal and watchdog. Stimulus pushes hand-computed
// expectations tagged with the cycle they are due; a monitor on the
// falling edge pops and compares them.
module tb_bus_scheduler;

  logic clk;
  logic clr;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  bus_scheduler_if ia();
  bus_scheduler_if ib();

  bus_scheduler #(.MAX_BURST(1), .TIMEOUT(8)) u_a (
    .clk (clk),
    .clr (clr),
    .bus (ia)
  );

  bus_scheduler #(.MAX_BURST(4), .TIMEOUT(8)) u_b (
    .clk (clk),
    .clr (clr),
    .bus (ib)
  );

  typedef struct {
    int         due;
    int         inst;
    logic [7:0] g;
    logic       te;
    logic [2:0] eid;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [7:0] ag;
  logic       ar;
  logic       ate;
  logic [2:0] aeid;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Monitor: compare every expectation whose due cycle has arrived.
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.inst == 0) begin
        ag = ia.grant; ar = ia.req; ate = ia.timeout_err; aeid = ia.err_id;
      end else begin
        ag = ib.grant; ar = ib.req; ate = ib.timeout_err; aeid = ib.err_id;
      end
      checks++;
      if (ag !== mon_e.g || ar !== (mon_e.g != 8'h00) ||
          ate !== mon_e.te || aeid !== mon_e.eid) begin
        failures++;
        $display("FAIL %s cyc=%0d inst=%0d got grant=%h req=%b terr=%b err_id=%0d want grant=%h req=%b terr=%b err_id=%0d",
                 mon_e.nm, cyc, mon_e.inst, ag, ar, ate, aeid,
                 mon_e.g, (mon_e.g != 8'h00), mon_e.te, mon_e.eid);
      end
    end
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic expect_out(input int dly, input int inst, input logic [7:0] g,
                            input logic te, input logic [2:0] eid, input string nm);
    exp_t e;
    e.due = cyc + dly; e.inst = inst; e.g = g; e.te = te; e.eid = eid; e.nm = nm;
    sb.push_back(e);
  endtask

  initial begin
    clr = 1'b1;
    ia.dma = 8'h00; ia.ready = 1'b0;
    ib.dma = 8'h00; ib.ready = 1'b0;
    #1 clr = 1'b0;
    ia.dma = 8'hFF; ib.dma = 8'hFF;

    // Reset and first grant
    tick(1);                                   // cyc1, clr still low
    expect_out(0, 0, 8'h00, 1'b0, 3'd0, "rst_a");
    expect_out(0, 1, 8'h00, 1'b0, 3'd0, "rst_b");
    clr = 1'b1;
    expect_out(1, 0, 8'h01, 1'b0, 3'd0, "first_grant_a");
    expect_out(1, 1, 8'h01, 1'b0, 3'd0, "first_grant_b");
    tick(1);                                   // cyc2
    ia.dma = 8'h00; ib.dma = 8'h00;
    expect_out(1, 0, 8'h00, 1'b0, 3'd0, "drop_a");
    expect_out(1, 1, 8'h00, 1'b0, 3'd0, "drop_b");
    tick(1);                                   // cyc3, both ptr=1

    // Round-robin rotation on A: masters 0 and 7, one ready per tenure
    ia.dma = 8'h81; ia.ready = 1'b1;
    expect_out(1, 0, 8'h80, 1'b0, 3'd0, "rr_m7");
    expect_out(2, 0, 8'h00, 1'b0, 3'd0, "rr_gap1");
    expect_out(3, 0, 8'h01, 1'b0, 3'd0, "rr_wrap_m0");
    expect_out(4, 0, 8'h00, 1'b0, 3'd0, "rr_gap2");
    expect_out(5, 0, 8'h80, 1'b0, 3'd0, "rr_m7_again");
    tick(5);                                   // cyc8
    ia.dma = 8'h00; ia.ready = 1'b0;
    expect_out(1, 0, 8'h00, 1'b0, 3'd0, "rr_end");
    tick(1);                                   // cyc9, A ptr=0

    // Burst cap on B: only master 2, ready every cycle
    ib.dma = 8'h04; ib.ready = 1'b1;
    expect_out(1, 1, 8'h04, 1'b0, 3'd0, "burst_x1");
    expect_out(2, 1, 8'h04, 1'b0, 3'd0, "burst_x2");
    expect_out(3, 1, 8'h04, 1'b0, 3'd0, "burst_x3");
    expect_out(4, 1, 8'h04, 1'b0, 3'd0, "burst_x4");
    expect_out(5, 1, 8'h00, 1'b0, 3'd0, "burst_gap");
    expect_out(6, 1, 8'h04, 1'b0, 3'd0, "burst_regrant");
    tick(6);                                   // cyc15
    ib.dma = 8'h00; ib.ready = 1'b0;
    expect_out(1, 1, 8'h00, 1'b0, 3'd0, "burst_end");
    tick(1);                                   // cyc16, B ptr=3

    // Withdrawal on B: master 5 drops, master 6 wins over master 0
    ib.dma = 8'h20;
    expect_out(1, 1, 8'h20, 1'b0, 3'd0, "wd_grant5");
    tick(1);                                   // cyc17
    ib.dma = 8'h41;
    expect_out(1, 1, 8'h00, 1'b0, 3'd0, "wd_release");
    expect_out(2, 1, 8'h40, 1'b0, 3'd0, "wd_next6");
    tick(2);                                   // cyc19
    ib.dma = 8'h00;
    expect_out(1, 1, 8'h00, 1'b0, 3'd0, "wd_end");
    tick(1);                                   // cyc20, B ptr=7

    // Watchdog on B: master 3, no ready
    ib.dma = 8'h08;
    expect_out(1,  1, 8'h08, 1'b0, 3'd0, "wdog_grant");
    expect_out(8,  1, 8'h08, 1'b0, 3'd0, "wdog_pre");
    expect_out(9,  1, 8'h00, 1'b1, 3'd3, "wdog_fire");
    expect_out(10, 1, 8'h08, 1'b0, 3'd3, "wdog_pulse_end");
    tick(10);                                  // cyc30, new grant edge
    tick(7);                                   // cyc37
    ib.ready = 1'b1;
    expect_out(1, 1, 8'h08, 1'b0, 3'd3, "wdog_ready_wins");
    tick(1);                                   // cyc38
    ib.ready = 1'b0;
    expect_out(1, 1, 8'h08, 1'b0, 3'd3, "wdog_cleared");
    tick(1);                                   // cyc39
    ib.dma = 8'h00;
    expect_out(1, 1, 8'h00, 1'b0, 3'd3, "wdog_end");
    tick(1);                                   // cyc40

    // Async reset mid-tenure on A
    ia.dma = 8'h10;
    expect_out(1, 0, 8'h10, 1'b0, 3'd0, "ar_grant");
    tick(2);                                   // cyc42, A still granted
    clr = 1'b0;
    expect_out(0, 0, 8'h00, 1'b0, 3'd0, "ar_async_a");
    expect_out(0, 1, 8'h00, 1'b0, 3'd0, "ar_async_b");
    tick(1);                                   // cyc43
    clr = 1'b1;
    expect_out(1, 0, 8'h10, 1'b0, 3'd0, "ar_regrant");
    tick(1);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick(1);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want pending=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
